// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register file write port,
// with a one-cycle stage register, per-register busy scoreboard and read forwarding.
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0_* / req1_*              ALU / memory write-back requests (valid, rd, data, ready)
//   issue_valid, issue_rd        destination allocation; issue_ready = !busy[issue_rd]
//   rs1/rs2, rs*_rf_data         read indices and raw register-file data
//   rs*_data, rs*_busy           forwarded read data and scoreboard bit of each source
//   wen, rd, rd_data             registered write port to the register file
//   busy                         scoreboard vector
`ifndef RF_SIZE_LOG
`define RF_SIZE_LOG 3
`endif
`ifndef REG_LEN
`define REG_LEN 8
`endif
module rf_wb_arbiter #(
    parameter int RF_SIZE_LOG = `RF_SIZE_LOG,
    parameter int REG_LEN = `REG_LEN,
    localparam int RF_SIZE = 1 << RF_SIZE_LOG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [RF_SIZE_LOG-1:0] req0_rd,
    input  logic [REG_LEN-1:0]     req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [RF_SIZE_LOG-1:0] req1_rd,
    input  logic [REG_LEN-1:0]     req1_data,
    output logic                   req1_ready,
    input  logic                   issue_valid,
    input  logic [RF_SIZE_LOG-1:0] issue_rd,
    output logic                   issue_ready,
    input  logic [RF_SIZE_LOG-1:0] rs1,
    input  logic [RF_SIZE_LOG-1:0] rs2,
    input  logic [REG_LEN-1:0]     rs1_rf_data,
    input  logic [REG_LEN-1:0]     rs2_rf_data,
    output logic [REG_LEN-1:0]     rs1_data,
    output logic [REG_LEN-1:0]     rs2_data,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   wen,
    output logic [RF_SIZE_LOG-1:0] rd,
    output logic [REG_LEN-1:0]     rd_data,
    output logic [RF_SIZE-1:0]     busy
);
    logic                   prio;
    logic                   grant;
    logic [RF_SIZE_LOG-1:0] g_rd;
    logic [REG_LEN-1:0]     g_data;
    logic [RF_SIZE-1:0]     busy_nxt;

    // Ready depends only on the valids and the pointer, never on itself.
    assign req0_ready  = req0_valid && (!req1_valid || !prio);
    assign req1_ready  = req1_valid && (!req0_valid || prio);
    assign grant       = req0_ready || req1_ready;
    assign g_rd        = req0_ready ? req0_rd : req1_rd;
    assign g_data      = req0_ready ? req0_data : req1_data;
    assign issue_ready = !busy[issue_rd];
    assign rs1_busy    = busy[rs1];
    assign rs2_busy    = busy[rs2];
    // The staged write has not reached the array yet, so bypass it.
    assign rs1_data    = (wen && rd == rs1) ? rd_data : rs1_rf_data;
    assign rs2_data    = (wen && rd == rs2) ? rd_data : rs2_rf_data;

    // Clear before set: a fresh allocation owns the register over a retiring write.
    always_comb begin
        busy_nxt = busy;
        if (grant) busy_nxt[g_rd] = 1'b0;
        if (issue_valid && issue_ready) busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen     <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
            prio    <= 1'b0;
            busy    <= '0;
        end else begin
            wen  <= grant;
            busy <= busy_nxt;
            if (grant) begin
                rd      <= g_rd;
                rd_data <= g_data;
                prio    <= req0_ready;
            end
        end
    end
endmodule
